// File: rtl/button_pkg.sv
// Shared definitions for the button front end: FSM state encoding and
// default tick counts for a 27 MHz system clock.
package button_pkg;

  localparam int unsigned LONG_TICKS_DEFAULT   = 27_000_000;
  localparam int unsigned GAP_TICKS_DEFAULT    = 8_100_000;
  localparam int unsigned REPEAT_TICKS_DEFAULT = 2_700_000;

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS1 = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4,
    LONG   = 3'd5
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture.sv
// Classifies a debounced button level into click, double-click, long-press,
// auto-repeat and long-release single-cycle event pulses.
module button_gesture
  import button_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = LONG_TICKS_DEFAULT,
  parameter int unsigned GAP_TICKS    = GAP_TICKS_DEFAULT,
  parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic long_release,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(max3(LONG_TICKS, GAP_TICKS, REPEAT_TICKS) + 1);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LIM  =
    (REPEAT_TICKS == 0) ? '0 : CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clear;

  logic click_q, click_d;
  logic dbl_q, dbl_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic rel_q, rel_d;
  logic busy_q;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    rel_d   = 1'b0;

    case (state_q)
      // ARM waits for a release so a button held through reset stays silent.
      ARM: begin
        if (!btn) state_d = IDLE;
      end
      IDLE: begin
        if (btn) state_d = PRESS1;
      end
      PRESS1: begin
        if (!btn) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LIM) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      WAIT2: begin
        if (btn) begin
          state_d = PRESS2;
        end else if (cnt_q == GAP_LIM) begin
          click_d = 1'b1;
          state_d = IDLE;
        end
      end
      // A second press held long still reports the first press as a click.
      PRESS2: begin
        if (!btn) begin
          dbl_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LONG_LIM) begin
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      LONG: begin
        if (!btn) begin
          rel_d   = 1'b1;
          state_d = IDLE;
        end else if ((REPEAT_TICKS != 0) && (cnt_q == REP_LIM)) begin
          rep_d = 1'b1;
          clear = 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // The counter only matters while timing a gesture, so it is parked at zero
  // in ARM and IDLE instead of free-running.
  always_comb begin
    if ((state_d != state_q) || clear || (state_q == ARM) || (state_q == IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARM;
      cnt_q   <= '0;
      click_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      rel_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      click_q <= click_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      rel_q   <= rel_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign click        = click_q;
  assign double_click = dbl_q;
  assign long_press   = long_q;
  assign repeat_tick  = rep_q;
  assign long_release = rel_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with short tick counts; dutA uses repeat
// period 3, dutB has auto-repeat disabled.
module tb_button_gesture;

  localparam logic [4:0] EV_NONE  = 5'b00000;
  localparam logic [4:0] EV_CLICK = 5'b10000;
  localparam logic [4:0] EV_DBL   = 5'b01000;
  localparam logic [4:0] EV_LONG  = 5'b00100;
  localparam logic [4:0] EV_REP   = 5'b00010;
  localparam logic [4:0] EV_REL   = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  logic clickA, dblA, longA, repA, relA, busyA;
  logic clickB, dblB, longB, repB, relB, busyB;
  logic [4:0] evA, evB;

  int passCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  button_gesture #(.LONG_TICKS(8), .GAP_TICKS(4), .REPEAT_TICKS(3)) dutA (
    .clk(clk), .rst(rst), .btn(btn),
    .click(clickA), .double_click(dblA), .long_press(longA),
    .repeat_tick(repA), .long_release(relA), .busy(busyA)
  );

  button_gesture #(.LONG_TICKS(8), .GAP_TICKS(4), .REPEAT_TICKS(0)) dutB (
    .clk(clk), .rst(rst), .btn(btn),
    .click(clickB), .double_click(dblB), .long_press(longB),
    .repeat_tick(repB), .long_release(relB), .busy(busyB)
  );

  assign evA = {clickA, dblA, longA, repA, relA};
  assign evB = {clickB, dblB, longB, repB, relB};

  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    totalCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    else
      passCount++;
  endtask

  // Drive btn for the next rising edge and sample outputs 1 time unit later.
  task automatic applyStimulus(input logic b);
    btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    #1;
    checkOutput("reset_events", evA, EV_NONE);
    checkOutput("reset_busy", {4'b0, busyA}, 5'b00001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] exp;

    // Single click
    doReset();
    for (int e = 1; e <= 22; e++) begin
      applyStimulus(e >= 10 && e <= 12);
      exp = (e == 17) ? EV_CLICK : EV_NONE;
      checkOutput($sformatf("click@%0d", e), evA, exp);
      if (e == 5)  checkOutput("click_busy_idle", {4'b0, busyA}, 5'b00000);
      if (e == 15) checkOutput("click_busy_wait", {4'b0, busyA}, 5'b00001);
      if (e == 17) checkOutput("click_busy_done", {4'b0, busyA}, 5'b00000);
    end

    // Double click
    doReset();
    for (int e = 1; e <= 22; e++) begin
      applyStimulus((e >= 10 && e <= 12) || (e >= 15 && e <= 16));
      exp = (e == 17) ? EV_DBL : EV_NONE;
      checkOutput($sformatf("double@%0d", e), evA, exp);
    end

    // Long press with auto-repeat
    doReset();
    for (int e = 1; e <= 34; e++) begin
      applyStimulus(e >= 10 && e <= 29);
      case (e)
        18:         exp = EV_LONG;
        21, 24, 27: exp = EV_REP;
        30:         exp = EV_REL;
        default:    exp = EV_NONE;
      endcase
      checkOutput($sformatf("long@%0d", e), evA, exp);
    end

    // Press, short gap, then hold: click and long_press together
    doReset();
    for (int e = 1; e <= 32; e++) begin
      applyStimulus((e >= 10 && e <= 12) || (e >= 14 && e <= 29));
      case (e)
        22:      exp = EV_CLICK | EV_LONG;
        25, 28:  exp = EV_REP;
        30:      exp = EV_REL;
        default: exp = EV_NONE;
      endcase
      checkOutput($sformatf("presshold@%0d", e), evA, exp);
    end

    // Reset while held mid-PRESS1
    doReset();
    for (int e = 1; e <= 12; e++) applyStimulus(e >= 10);
    rst = 1'b1;
    #1;
    checkOutput("midrst_events", evA, EV_NONE);
    checkOutput("midrst_busy", {4'b0, busyA}, 5'b00001);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("armheld@%0d", j), {evA, busyA} == {EV_NONE, 1'b1} ? 5'd1 : 5'd0, 5'd1);
    end
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(j >= 2 && j <= 4);
      if (j == 1) checkOutput("arm_release_busy", {4'b0, busyA}, 5'b00000);
      exp = (j == 9) ? EV_CLICK : EV_NONE;
      checkOutput($sformatf("postrst_click@%0d", j), evA, exp);
    end

    // Repeat disabled: one long_press, one long_release, no repeats
    doReset();
    for (int e = 1; e <= 44; e++) begin
      applyStimulus(e >= 10 && e <= 39);
      case (e)
        18:      exp = EV_LONG;
        40:      exp = EV_REL;
        default: exp = EV_NONE;
      endcase
      checkOutput($sformatf("norepeat@%0d", e), evB, exp);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
